text_console: RTL and testbench

Character-stream writer for the 40x24 text page in the shared 64K address space. It is the producer side of the text page; the video display processor scans the same page and renders it. The block accepts bytes over a valid/ready handshake, writes printable codes at a hardware cursor, and handles newline, backspace, clear-screen, line wrap and scroll-up. It drives one byte-wide memory port with 1-cycle synchronous read latency.

---
 rtl/text_pkg.sv | 34 +++
 rtl/txt_addr_map.sv | 15 +
 rtl/text_console.sv | 218 +++++++++++++++++++++
 tb/tb_text_console.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared definitions for the 40x24 text page: geometry, control codes,
// writer FSM states and the cell address map used by writer and display.
package text_pkg;

   localparam int          TXT_COLS = 40;
   localparam int          TXT_ROWS = 24;
   localparam logic [5:0]  COL_LAST = 6'(TXT_COLS - 1);
   localparam logic [4:0]  ROW_LAST = 5'(TXT_ROWS - 1);

   localparam logic [6:0]  CC_CR = 7'h0D;
   localparam logic [6:0]  CC_BS = 7'h08;
   localparam logic [6:0]  CC_FF = 7'h0C;
   localparam logic [6:0]  CC_LF = 7'h0A;

   typedef enum logic [2:0] {
      IDLE, WRITE, SCROLL_RD, SCROLL_WR, BLANK_ROW, CLEAR
   } state_t;

   // Cell address: linear rows of 40, or the Apple II layout where rows
   // 0..7 sit at 128-byte strides and each third of the screen adds 40.
   function automatic logic [15:0] txt_addr(input logic [4:0]  row,
                                            input logic [5:0]  col,
                                            input logic [15:0] base,
                                            input logic        interleave);
      logic [15:0] r16, c16;
      r16 = {11'd0, row};
      c16 = {10'd0, col};
      if (interleave)
         return base + {6'd0, row[2:0], 7'd0} + {14'd0, row[4:3]} * 16'd40 + c16;
      else
         return base + r16 * 16'd40 + c16;
   endfunction

endpackage

// File: rtl/txt_addr_map.sv
// Combinational cell-to-address mapper around the shared txt_addr function.
module txt_addr_map
   import text_pkg::*;
#(
   parameter int          INTERLEAVE = 0,
   parameter logic [15:0] BASE       = 16'h0400
) (
   input  logic [4:0]  row,
   input  logic [5:0]  col,
   output logic [15:0] adr
);

   assign adr = txt_addr(row, col, BASE, INTERLEAVE != 0);

endmodule

// File: rtl/text_console.sv
// Character-stream writer for the 40x24 text page: cursor, control codes,
// line wrap, scroll-up through a 1-cycle-latency memory port, and clear.
module text_console
   import text_pkg::*;
#(
   parameter int          INTERLEAVE = 0,
   parameter logic [15:0] BASE       = 16'h0400,
   parameter logic [7:0]  BLANK      = 8'hA0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  ch,
   input  logic        ch_valid,
   output logic        ch_ready,
   output logic [15:0] mem_adr,
   output logic [7:0]  mem_d,
   output logic        mem_we,
   input  logic [7:0]  mem_q,
   output logic [5:0]  cur_col,
   output logic [4:0]  cur_row,
   output logic        busy
);

   state_t      state;
   logic [7:0]  mem_d_r;
   logic [5:0]  scol;
   logic [4:0]  srow;
   logic        scroll_pend;

   logic        accept, scan_last_col;
   logic [6:0]  code;
   logic [5:0]  ncol, am_col;
   logic [4:0]  nrow, am_row;
   logic [15:0] am_adr;

   // Decode and next scan position; pick the cell whose address is loaded next
   always_comb begin
      accept        = ch_valid && ch_ready;
      code          = ch[6:0];
      scan_last_col = (scol == COL_LAST);
      ncol          = scan_last_col ? 6'd0 : scol + 6'd1;
      nrow          = scan_last_col ? srow + 5'd1 : srow;
      am_row        = cur_row;
      am_col        = cur_col;
      case (state)
         IDLE: begin
            if (code == CC_FF) begin
               am_row = 5'd0;
               am_col = 6'd0;
            end else if (code == CC_CR) begin
               am_row = 5'd1;
               am_col = 6'd0;
            end
         end
         WRITE: begin
            am_row = 5'd1;
            am_col = 6'd0;
         end
         SCROLL_RD: begin
            am_row = srow;
            am_col = scol;
         end
         SCROLL_WR: begin
            if (srow == ROW_LAST - 5'd1 && scan_last_col) begin
               am_row = ROW_LAST;
               am_col = 6'd0;
            end else begin
               am_row = nrow + 5'd1;
               am_col = ncol;
            end
         end
         BLANK_ROW: begin
            am_row = ROW_LAST;
            am_col = ncol;
         end
         CLEAR: begin
            am_row = nrow;
            am_col = ncol;
         end
         default: ;
      endcase
   end

   txt_addr_map #(.INTERLEAVE(INTERLEAVE), .BASE(BASE)) u_map (
      .row (am_row),
      .col (am_col),
      .adr (am_adr)
   );

   // Read data is only valid in the copy cycle, so it bypasses the data register there
   assign mem_d = (state == SCROLL_WR) ? mem_q : mem_d_r;

   // Writer FSM; all memory-port and cursor outputs are registered here
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ch_ready    <= 1'b0;
         mem_we      <= 1'b0;
         mem_adr     <= BASE;
         mem_d_r     <= 8'h00;
         cur_col     <= 6'd0;
         cur_row     <= 5'd0;
         busy        <= 1'b0;
         scol        <= 6'd0;
         srow        <= 5'd0;
         scroll_pend <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ch_ready <= 1'b1;
               if (accept) begin
                  if (code == CC_FF) begin
                     state    <= CLEAR;
                     ch_ready <= 1'b0;
                     busy     <= 1'b1;
                     mem_we   <= 1'b1;
                     mem_adr  <= am_adr;
                     mem_d_r  <= BLANK;
                     srow     <= 5'd0;
                     scol     <= 6'd0;
                     cur_col  <= 6'd0;
                     cur_row  <= 5'd0;
                  end else if (code == CC_CR) begin
                     cur_col <= 6'd0;
                     if (cur_row == ROW_LAST) begin
                        state    <= SCROLL_RD;
                        ch_ready <= 1'b0;
                        busy     <= 1'b1;
                        mem_adr  <= am_adr;
                        srow     <= 5'd0;
                        scol     <= 6'd0;
                     end else begin
                        cur_row <= cur_row + 5'd1;
                     end
                  end else if (code == CC_BS) begin
                     if (cur_col != 6'd0) begin
                        cur_col <= cur_col - 6'd1;
                     end else if (cur_row != 5'd0) begin
                        cur_col <= COL_LAST;
                        cur_row <= cur_row - 5'd1;
                     end
                  end else if (code != CC_LF) begin
                     state    <= WRITE;
                     ch_ready <= 1'b0;
                     mem_we   <= 1'b1;
                     mem_adr  <= am_adr;
                     mem_d_r  <= ch;
                     if (cur_col == COL_LAST) begin
                        cur_col <= 6'd0;
                        if (cur_row == ROW_LAST) scroll_pend <= 1'b1;
                        else                     cur_row     <= cur_row + 5'd1;
                     end else begin
                        cur_col <= cur_col + 6'd1;
                     end
                  end
               end
            end
            WRITE: begin
               mem_we <= 1'b0;
               if (scroll_pend) begin
                  scroll_pend <= 1'b0;
                  state       <= SCROLL_RD;
                  busy        <= 1'b1;
                  mem_adr     <= am_adr;
                  srow        <= 5'd0;
                  scol        <= 6'd0;
               end else begin
                  state    <= IDLE;
                  ch_ready <= 1'b1;
               end
            end
            SCROLL_RD: begin
               state   <= SCROLL_WR;
               mem_we  <= 1'b1;
               mem_adr <= am_adr;
            end
            SCROLL_WR: begin
               mem_adr <= am_adr;
               if (srow == ROW_LAST - 5'd1 && scan_last_col) begin
                  state   <= BLANK_ROW;
                  mem_d_r <= BLANK;
                  scol    <= 6'd0;
               end else begin
                  state  <= SCROLL_RD;
                  mem_we <= 1'b0;
                  scol   <= ncol;
                  srow   <= nrow;
               end
            end
            BLANK_ROW: begin
               if (scan_last_col) begin
                  state    <= IDLE;
                  mem_we   <= 1'b0;
                  busy     <= 1'b0;
                  ch_ready <= 1'b1;
               end else begin
                  scol    <= ncol;
                  mem_adr <= am_adr;
               end
            end
            CLEAR: begin
               if (srow == ROW_LAST && scan_last_col) begin
                  state    <= IDLE;
                  mem_we   <= 1'b0;
                  busy     <= 1'b0;
                  ch_ready <= 1'b1;
               end else begin
                  scol    <= ncol;
                  srow    <= nrow;
                  mem_adr <= am_adr;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: linear-map instance with a memory model,
// plus an interleaved instance sharing the input stream.
module tb_text_console;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  ch = 8'h00;
   logic        ch_valid = 1'b0;

   logic        rdy0, we0, busy0, rdy1, we1, busy1;
   logic [15:0] adr0, adr1;
   logic [7:0]  d0, d1, mem_q0;
   logic [5:0]  col0, col1;
   logic [4:0]  row0, row1;

   logic [7:0]  mem [0:1023];
   logic        preload = 1'b0;
   logic [15:0] off0, off1;

   int wr0 = 0, a0_0 = 0, cp0 = 0, cpbad = 0, blk23 = 0, wr1 = 0, holes = 0, busy_cyc = 0;
   int n_chk = 0, n_pass = 0;
   int s_wr0, s_a0, s_cp, s_bad, s_blk, s_wr1, s_holes, s_busy;

   always #5 clk = ~clk;

   text_console #(.INTERLEAVE(0)) u0 (
      .clk(clk), .reset(reset), .ch(ch), .ch_valid(ch_valid), .ch_ready(rdy0),
      .mem_adr(adr0), .mem_d(d0), .mem_we(we0), .mem_q(mem_q0),
      .cur_col(col0), .cur_row(row0), .busy(busy0));

   text_console #(.INTERLEAVE(1)) u1 (
      .clk(clk), .reset(reset), .ch(ch), .ch_valid(ch_valid), .ch_ready(rdy1),
      .mem_adr(adr1), .mem_d(d1), .mem_we(we1), .mem_q(8'h00),
      .cur_col(col1), .cur_row(row1), .busy(busy1));

   assign off0 = adr0 - 16'h0400;
   assign off1 = adr1 - 16'h0400;

   // Synchronous memory model and write classification
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'(i / 40);
      end else if (we0) begin
         mem[off0[9:0]] <= d0;
      end
      mem_q0 <= mem[off0[9:0]];
      if (we0) begin
         wr0 = wr0 + 1;
         if (d0 == 8'hA0) a0_0 = a0_0 + 1;
         if (off0 < 16'd920) begin
            cp0 = cp0 + 1;
            if (d0 != 8'(off0 / 16'd40 + 16'd1)) cpbad = cpbad + 1;
         end else if (d0 == 8'hA0) begin
            blk23 = blk23 + 1;
         end
      end
      if (we1) begin
         wr1 = wr1 + 1;
         if (off1[6:0] >= 7'h78) holes = holes + 1;
      end
   end

   // Busy cycle counter
   always @(negedge clk) if (busy0) busy_cyc = busy_cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic send(input logic [7:0] c);
      int n = 0;
      @(negedge clk);
      ch = c;
      ch_valid = 1'b1;
      while (!rdy0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 4000) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1 ch_valid = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!rdy0 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 4000) chk("ready_timeout", 0, 1);
   endtask

   task automatic snap();
      s_wr0 = wr0; s_a0 = a0_0; s_cp = cp0; s_bad = cpbad; s_blk = blk23;
      s_wr1 = wr1; s_holes = holes; s_busy = busy_cyc;
   endtask

   initial begin
      // reset values
      #3 reset = 1'b0;
      #20;
      chk("rst_ready", rdy0, 0);
      chk("rst_we", we0, 0);
      chk("rst_adr", adr0, 16'h0400);
      chk("rst_d", d0, 0);
      chk("rst_cur", {col0, row0}, 0);
      chk("rst_busy", busy0, 0);
      @(negedge clk) reset = 1'b1;
      #1 chk("rel_ready_low", rdy0, 0);
      @(posedge clk); #1;
      chk("rel_ready_high", rdy0, 1);

      // backspace at home: no write, no move
      snap();
      send(8'h08);
      @(posedge clk); #1;
      chk("bs_home_nowrite", wr0 - s_wr0, 0);
      chk("bs_home_cur", {col0, row0}, {6'd0, 5'd0});

      // first printable
      send(8'hC1);
      chk("wr_we", we0, 1);
      chk("wr_adr", adr0, 16'h0400);
      chk("wr_d", d0, 8'hC1);
      chk("wr_cur", {col0, row0}, {6'd1, 5'd0});
      @(posedge clk); #1;
      chk("wr_pulse_one", we0, 0);
      chk("wr_ready_back", rdy0, 1);

      // CR then printable on both maps
      send(8'h8D);
      chk("cr_cur", {col0, row0}, {6'd0, 5'd1});
      send(8'hC2);
      chk("lin_adr", adr0, 16'h0428);
      chk("ilv_adr", adr1, 16'h0480);
      chk("ilv_we", we1, 1);
      chk("lf_pre_cur", {col0, row0}, {6'd1, 5'd1});
      send(8'h0A);
      @(posedge clk); #1;
      chk("lf_ignored", {col0, row0}, {6'd1, 5'd1});

      // backspace across a row boundary
      repeat (4) send(8'h0D);
      chk("cr4_cur", {col0, row0}, {6'd0, 5'd5});
      send(8'h08);
      chk("bs_wrap_cur", {col0, row0}, {6'd39, 5'd4});

      // clear screen
      snap();
      send(8'h0C);
      wait_ready();
      chk("ff_writes", wr0 - s_wr0, 960);
      chk("ff_blank_writes", a0_0 - s_a0, 960);
      chk("ff_ilv_writes", wr1 - s_wr1, 960);
      chk("ff_no_holes", holes - s_holes, 0);
      chk("ff_busy_cycles", busy_cyc - s_busy, 960);
      chk("ff_cur", {col0, row0}, 0);
      chk("ff_mem", mem[517], 8'hA0);

      // scroll: preload row r with value r, fill row 23, overflow
      @(negedge clk) preload = 1'b1;
      @(negedge clk) preload = 1'b0;
      repeat (23) send(8'h0D);
      chk("row23_cur", {col0, row0}, {6'd0, 5'd23});
      repeat (39) send(8'h17);
      snap();
      send(8'h17);
      wait_ready();
      chk("scr_copies", cp0 - s_cp, 920);
      chk("scr_copy_data", cpbad - s_bad, 0);
      chk("scr_blank23", blk23 - s_blk, 40);
      chk("scr_busy_cycles", busy_cyc - s_busy, 1880);
      chk("scr_cur", {col0, row0}, {6'd0, 5'd23});
      chk("scr_mem_row0", mem[3], 8'd1);
      chk("scr_mem_row22", mem[22 * 40 + 3], 8'd23);
      chk("scr_mem_row23", mem[23 * 40 + 10], 8'hA0);
      send(8'hC5);
      @(posedge clk); #1;
      chk("post_scr_mem", mem[920], 8'hC5);
      chk("post_scr_cur", {col0, row0}, {6'd1, 5'd23});

      // reset in the middle of a clear
      send(8'h0C);
      repeat (10) @(negedge clk);
      chk("mid_busy", busy0, 1);
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", busy0, 0);
      chk("mid_rst_we", we0, 0);
      chk("mid_rst_adr", adr0, 16'h0400);
      chk("mid_rst_cur", {col0, row0}, 0);
      chk("mid_rst_ready", rdy0, 0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rel_ready", rdy0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
